// File: rtl/bus_datapath.sv
// Single-bus 32-bit CPU datapath: GPRs, HI/LO, PC, IR, Y, 64-bit Z, MDR/MAR and the ALU.
// Define DATAPATH_DIV_EN to build the signed divider; otherwise opcode 10000 yields 0.
module bus_datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] Mdatain,
    input  logic        Read,
    input  logic        IncPC,
    input  logic [15:0] R0_15_enable_in,
    input  logic [15:0] R0_15_out_in,
    input  logic        PC_enable,
    input  logic        Z_enable,
    input  logic        MDR_enable,
    input  logic        MAR_enable,
    input  logic        Y_enable,
    input  logic        HI_enable,
    input  logic        LO_enable,
    input  logic        IR_enable,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        ZHighout,
    input  logic        ZLowout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        InPortout,
    input  logic        Cout,
    input  logic [31:0] InPort_data,
    input  logic [4:0]  opcode,
    output logic [31:0] busout,
    output logic [31:0] MAR_data,
    output logic [31:0] IR_data
);

    logic [31:0] gpr_q [16];
    logic [31:0] hi_q, lo_q, zhi_q, zlo_q, pc_q, y_q, ir_q, mdr_q, mar_q;
    logic [31:0] mdr_d, zhi_d, zlo_d;

    logic [23:0] sel;
    logic [31:0] src [24];
    logic [31:0] bus;

    assign sel = {Cout, InPortout, MDRout, PCout, ZLowout, ZHighout, LOout, HIout, R0_15_out_in};

    always_comb begin
        for (int i = 0; i < 16; i++) src[i] = gpr_q[i];
        src[16] = hi_q;
        src[17] = lo_q;
        src[18] = zhi_q;
        src[19] = zlo_q;
        src[20] = pc_q;
        src[21] = mdr_q;
        src[22] = InPort_data;
        src[23] = {{13{ir_q[18]}}, ir_q[18:0]};
    end

    // Scan from the top so the lowest asserted index is the last (winning) assignment.
    always_comb begin
        bus = '0;
        for (int i = 23; i >= 0; i--) begin
            if (sel[i]) bus = src[i];
        end
    end

    logic signed [31:0] a_s, b_s;
    logic signed [63:0] prod;
    logic [63:0]        rot_r, rot_l;
    logic [4:0]         sh;

    assign a_s   = $signed(y_q);
    assign b_s   = $signed(bus);
    assign sh    = bus[4:0];
    assign prod  = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
    assign rot_r = {y_q, y_q} >> sh;
    assign rot_l = {y_q, y_q} << sh;

    always_comb begin
        zhi_d = '0;
        zlo_d = '0;
        if (IncPC) begin
            zlo_d = bus + 32'd1;
        end else begin
            case (opcode)
                5'b00000, 5'b00001, 5'b00010,
                5'b00011, 5'b01100:          zlo_d = y_q + bus;
                5'b00100:                    zlo_d = y_q - bus;
                5'b00101, 5'b01101:          zlo_d = y_q & bus;
                5'b00110, 5'b01110:          zlo_d = y_q | bus;
                5'b00111:                    zlo_d = y_q >> sh;
                5'b01000:                    zlo_d = $unsigned(a_s >>> sh);
                5'b01001:                    zlo_d = y_q << sh;
                5'b01010:                    zlo_d = rot_r[31:0];
                5'b01011:                    zlo_d = rot_l[63:32];
                5'b01111: begin
                    zhi_d = prod[63:32];
                    zlo_d = prod[31:0];
                end
`ifdef DATAPATH_DIV_EN
                5'b10000: begin
                    if (bus == 32'd0) begin
                        zhi_d = y_q;
                    end else if (b_s == -32'sd1) begin
                        // Handled apart so INT_MIN / -1 wraps instead of overflowing.
                        zlo_d = -y_q;
                    end else begin
                        zlo_d = $unsigned(a_s / b_s);
                        zhi_d = $unsigned(a_s % b_s);
                    end
                end
`endif
                5'b10001:                    zlo_d = -bus;
                5'b10010:                    zlo_d = ~bus;
                default: ;
            endcase
        end
    end

    assign mdr_d = Read ? Mdatain : bus;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
            pc_q  <= '0;
            y_q   <= '0;
            ir_q  <= '0;
            mdr_q <= '0;
            mar_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (R0_15_enable_in[i]) gpr_q[i] <= bus;
            end
            if (HI_enable)  hi_q  <= bus;
            if (LO_enable)  lo_q  <= bus;
            if (PC_enable)  pc_q  <= bus;
            if (Y_enable)   y_q   <= bus;
            if (IR_enable)  ir_q  <= bus;
            if (MAR_enable) mar_q <= bus;
            if (MDR_enable) mdr_q <= mdr_d;
            if (Z_enable) begin
                zhi_q <= zhi_d;
                zlo_q <= zlo_d;
            end
        end
    end

    assign busout   = bus;
    assign MAR_data = mar_q;
    assign IR_data  = ir_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Scoreboard bench for bus_datapath: expected bus values are queued when stimulus is
// driven and compared against busout when the selected source is observed.
module tb_bus_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] Mdatain;
    logic        Read, IncPC;
    logic [15:0] R0_15_enable_in, R0_15_out_in;
    logic        PC_enable, Z_enable, MDR_enable, MAR_enable, Y_enable, HI_enable, LO_enable, IR_enable;
    logic        HIout, LOout, ZHighout, ZLowout, PCout, MDRout, InPortout, Cout;
    logic [31:0] InPort_data;
    logic [4:0]  opcode;
    logic [31:0] busout, MAR_data, IR_data;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    bus_datapath dut (
        .clk(clk), .clr(clr), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
        .R0_15_enable_in(R0_15_enable_in), .R0_15_out_in(R0_15_out_in),
        .PC_enable(PC_enable), .Z_enable(Z_enable), .MDR_enable(MDR_enable),
        .MAR_enable(MAR_enable), .Y_enable(Y_enable), .HI_enable(HI_enable),
        .LO_enable(LO_enable), .IR_enable(IR_enable),
        .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .ZLowout(ZLowout),
        .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
        .InPort_data(InPort_data), .opcode(opcode),
        .busout(busout), .MAR_data(MAR_data), .IR_data(IR_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    // Caller has set the bus selects; sample busout on the falling edge.
    task automatic observe(input string tag, input logic [31:0] v);
        exp_t e;
        push(tag, v);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            check(e.tag, busout, e.val);
        end
    endtask

    task automatic idle();
        Read = 0; IncPC = 0; opcode = '0;
        R0_15_enable_in = '0; R0_15_out_in = '0;
        PC_enable = 0; Z_enable = 0; MDR_enable = 0; MAR_enable = 0;
        Y_enable = 0; HI_enable = 0; LO_enable = 0; IR_enable = 0;
        HIout = 0; LOout = 0; ZHighout = 0; ZLowout = 0;
        PCout = 0; MDRout = 0; InPortout = 0; Cout = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_gpr(input int n, input logic [31:0] v);
        idle();
        InPort_data = v; InPortout = 1; R0_15_enable_in[n] = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_gpr(input int n, input string tag, input logic [31:0] v);
        idle();
        R0_15_out_in[n] = 1'b1;
        observe(tag, v);
        idle();
    endtask

    task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        idle();
        InPort_data = a; InPortout = 1; Y_enable = 1;
        tick();
        idle();
        InPort_data = b; InPortout = 1; opcode = op; Z_enable = 1;
        tick();
        idle();
    endtask

    task automatic read_z(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        idle(); ZHighout = 1; observe({tag, "_hi"}, hi);
        idle(); ZLowout  = 1; observe({tag, "_lo"}, lo);
        idle();
    endtask

    function automatic logic [31:0] model_lo(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'b00000: return a + b;
            5'b00100: return a + (~b + 32'd1);
            5'b01101: return ~(~a | ~b);
            5'b00110: return ~(~a & ~b);
            5'b10001: return 32'd0 - b;
            5'b10010: return b ^ 32'hFFFF_FFFF;
            default:  return 32'd0;
        endcase
    endfunction

    initial begin
        logic [4:0]  ops [6];
        logic [31:0] ra, rb;
        ops = '{5'b00000, 5'b00100, 5'b01101, 5'b00110, 5'b10001, 5'b10010};
        idle();
        InPort_data = '0; Mdatain = '0;
        clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus", busout, 32'h0);
        check("rst_mar", MAR_data, 32'h0);
        check("rst_ir", IR_data, 32'h0);
        // Enables are ignored while clr is low.
        InPort_data = 32'h77; InPortout = 1; R0_15_enable_in[7] = 1'b1;
        tick();
        idle();
        @(negedge clk);
        clr = 1;
        read_gpr(7, "r7_held_in_rst", 32'h0);
        ZLowout = 1; observe("rst_zlo", 32'h0); idle();

        load_gpr(3, 32'h5);
        read_gpr(3, "r3_load", 32'h5);
        #2 clr = 0;
        #2 clr = 1;
        read_gpr(3, "r3_after_clr", 32'h0);

        // MDR from memory, then R2 -> Y, R4 on the bus.
        idle(); Mdatain = 32'h34; Read = 1; MDR_enable = 1; tick(); idle();
        MDRout = 1; R0_15_enable_in[2] = 1'b1; observe("mdr_read", 32'h34); tick(); idle();
        R0_15_out_in[2] = 1'b1; Y_enable = 1; observe("r2_bus", 32'h34); tick(); idle();
        load_gpr(4, 32'h45);
        R0_15_out_in[4] = 1'b1; opcode = 5'b00101; Z_enable = 1; tick(); idle();
        read_z("and", 32'h0, 32'h04);
        R0_15_out_in[4] = 1'b1; opcode = 5'b00011; Z_enable = 1; tick(); idle();
        read_z("add", 32'h0, 32'h79);

        // MDR loads the bus when Read is low.
        idle(); InPort_data = 32'h1234; InPortout = 1; Mdatain = 32'hBAD; MDR_enable = 1; tick(); idle();
        MDRout = 1; observe("mdr_from_bus", 32'h1234); idle();

        alu(32'hFFFF_FFFE, 32'h3, 5'b01111);
        read_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
`ifdef DATAPATH_DIV_EN
        alu(-32'sd7, 32'd2, 5'b10000); read_z("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        alu(-32'sd7, 32'd0, 5'b10000); read_z("div0", 32'hFFFF_FFF9, 32'h0);
`else
        alu(-32'sd7, 32'd2, 5'b10000); read_z("div", 32'h0, 32'h0);
        alu(-32'sd7, 32'd0, 5'b10000); read_z("div0", 32'h0, 32'h0);
`endif
        alu(32'h8000_0001, 32'h1, 5'b01000); read_z("shra", 32'h0, 32'hC000_0000);
        alu(32'h8000_0001, 32'h1, 5'b00111); read_z("shr",  32'h0, 32'h4000_0000);
        alu(32'h8000_0001, 32'h1, 5'b01010); read_z("ror",  32'h0, 32'hC000_0000);
        alu(32'h8000_0001, 32'h1, 5'b01011); read_z("rol",  32'h0, 32'h0000_0003);
        alu(32'h0000_00F0, 32'h4, 5'b01001); read_z("shl",  32'h0, 32'h0000_0F00);
        alu(32'h1234_5678, 32'h1, 5'b10011); read_z("undef_op", 32'h0, 32'h0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            alu(ra, rb, ops[i]);
            read_z($sformatf("rnd%0d", i), 32'h0, model_lo(ops[i], ra, rb));
        end

        // Select priority and IncPC.
        load_gpr(1, 32'hA);
        idle(); InPort_data = 32'h10; InPortout = 1; PC_enable = 1; tick(); idle();
        R0_15_out_in[1] = 1'b1; PCout = 1; observe("prio_r1_pc", 32'hA); idle();
        PCout = 1; MDRout = 1; observe("prio_pc_mdr", 32'h10); idle();
        PCout = 1; IncPC = 1; opcode = 5'b01111; Z_enable = 1; tick(); idle();
        read_z("incpc", 32'h0, 32'h11);

        idle(); InPort_data = 32'h0004_0000; InPortout = 1; IR_enable = 1; tick(); idle();
        check("ir_data", IR_data, 32'h0004_0000);
        Cout = 1; observe("cout_neg", 32'hFFFC_0000); idle();
        idle(); InPort_data = 32'hFFF3_FFFF; InPortout = 1; IR_enable = 1; tick(); idle();
        Cout = 1; observe("cout_pos", 32'h0003_FFFF); idle();

        idle(); InPort_data = 32'hDEAD_0000; InPortout = 1; MAR_enable = 1; tick(); idle();
        check("mar_data", MAR_data, 32'hDEAD_0000);

        idle(); InPort_data = 32'h1111_2222; InPortout = 1; HI_enable = 1; tick(); idle();
        idle(); InPort_data = 32'h3333_4444; InPortout = 1; LO_enable = 1; tick(); idle();
        HIout = 1; observe("hi", 32'h1111_2222); idle();
        LOout = 1; observe("lo", 32'h3333_4444); idle();
        HIout = 1; LOout = 1; observe("prio_hi_lo", 32'h1111_2222); idle();

        // Drive and load in the same cycle; multiple destinations share the bus value.
        load_gpr(5, 32'h7);
        R0_15_out_in[5] = 1'b1; R0_15_enable_in[5] = 1'b1; R0_15_enable_in[6] = 1'b1; tick(); idle();
        read_gpr(5, "r5_self", 32'h7);
        read_gpr(6, "r6_multi", 32'h7);
        load_gpr(0, 32'hCAFE);
        R0_15_out_in = 16'hFFFF; observe("prio_all_gpr", 32'hCAFE); idle();
        observe("no_select", 32'h0);

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
